// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle control unit of the 16-bit CPU.
// Holds opcode and func codes, ALU operation codes, the controller state
// encoding and the source-select codes used by the datapath multiplexers.
// No ports; imported by multicycle_control and control_output_decode.
package multicycle_control_pkg;

    localparam int WORD_SIZE = 16;

    // Instruction opcodes, inst[15:12]
    localparam logic [3:0] OPC_BNE   = 4'd0;
    localparam logic [3:0] OPC_BEQ   = 4'd1;
    localparam logic [3:0] OPC_BGZ   = 4'd2;
    localparam logic [3:0] OPC_BLZ   = 4'd3;
    localparam logic [3:0] OPC_ADI   = 4'd4;
    localparam logic [3:0] OPC_ORI   = 4'd5;
    localparam logic [3:0] OPC_LHI   = 4'd6;
    localparam logic [3:0] OPC_LWD   = 4'd7;
    localparam logic [3:0] OPC_SWD   = 4'd8;
    localparam logic [3:0] OPC_JMP   = 4'd9;
    localparam logic [3:0] OPC_JAL   = 4'd10;
    localparam logic [3:0] OPC_RTYPE = 4'd15;

    // R-type function codes, inst[5:0]; codes 0..7 are plain ALU operations
    localparam logic [5:0] FUNC_JPR = 6'd25;
    localparam logic [5:0] FUNC_JRL = 6'd26;
    localparam logic [5:0] FUNC_WWD = 6'd28;
    localparam logic [5:0] FUNC_HLT = 6'd29;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_NOT = 3'd4;
    localparam logic [2:0] ALU_TCP = 3'd5;
    localparam logic [2:0] ALU_SHL = 3'd6;
    localparam logic [2:0] ALU_SHR = 3'd7;

    // ALU B operand select
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_ONE  = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_ZERO = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Register file destination select
    localparam logic [1:0] REGDST_RT  = 2'b00;
    localparam logic [1:0] REGDST_RD  = 2'b01;
    localparam logic [1:0] REGDST_R2  = 2'b10;

    // Register write-data select
    localparam logic [1:0] MEMTOREG_ALU = 2'b00;
    localparam logic [1:0] MEMTOREG_MEM = 2'b01;
    localparam logic [1:0] MEMTOREG_PC  = 2'b10;
    localparam logic [1:0] MEMTOREG_LHI = 2'b11;

    // Controller states
    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } stateT;

    // True for R-type func codes that are plain ALU operations (0..7)
    function automatic logic isAluFunc(input logic [5:0] func);
        return (func[5:3] == 3'b000);
    endfunction

endpackage

// File: rtl/multicycle_control_decode.sv
// control_output_decode: purely combinational strobe decoder.
// Ports:
//   enable     in  1   low forces every output to 0 (held in reset)
//   state      in  3   current controller state (stateT encoding)
//   opcode     in  4   latched opcode of the instruction in flight
//   func       in  6   latched func field
//   memAck     in  1   memory acknowledge (only matters in IF)
//   readM1/readM2/writeM2, ctrl* strobes, isHalted  out  as in top level
module control_output_decode
    import multicycle_control_pkg::*;
(
    input  logic       enable,
    input  logic [2:0] state,
    input  logic [3:0] opcode,
    input  logic [5:0] func,
    input  logic       memAck,
    output logic       readM1,
    output logic       readM2,
    output logic       writeM2,
    output logic       ctrlPCWrite,
    output logic       ctrlPCWriteCond,
    output logic       ctrlIRWrite,
    output logic       ctrlALUSrcA,
    output logic       ctrlRegWrite,
    output logic       ctrlWritePort,
    output logic [1:0] ctrlMemtoReg,
    output logic [1:0] ctrlPCSource,
    output logic [1:0] ctrlALUSrcB,
    output logic [1:0] ctrlRegDst,
    output logic [2:0] ctrlALUOp,
    output logic       isHalted
);

    // Every strobe starts at 0 and only the ones a state needs are raised.
    // While enable is low nothing is raised, so reset silences the datapath
    // immediately even though the state register already reads IF.
    always_comb begin
        readM1          = 1'b0;
        readM2          = 1'b0;
        writeM2         = 1'b0;
        ctrlPCWrite     = 1'b0;
        ctrlPCWriteCond = 1'b0;
        ctrlIRWrite     = 1'b0;
        ctrlALUSrcA     = 1'b0;
        ctrlRegWrite    = 1'b0;
        ctrlWritePort   = 1'b0;
        ctrlMemtoReg    = MEMTOREG_ALU;
        ctrlPCSource    = PCSRC_ALU;
        ctrlALUSrcB     = SRCB_REG;
        ctrlRegDst      = REGDST_RT;
        ctrlALUOp       = ALU_ADD;
        isHalted        = 1'b0;
        if (enable) begin
            case (stateT'(state))
                S_IF: begin
                    readM1 = 1'b1;
                    // PC and IR only move on the cycle memory delivers the word
                    if (memAck) begin
                        ctrlIRWrite = 1'b1;
                        ctrlALUSrcB = SRCB_ONE;
                        ctrlPCWrite = 1'b1;
                    end
                end
                S_ID: begin
                    // ALUOut <= PC+1+imm, the branch target used later in EX
                    ctrlALUSrcB = SRCB_IMM;
                    if (opcode == OPC_JMP || opcode == OPC_JAL) begin
                        ctrlPCSource = PCSRC_JUMP;
                        ctrlPCWrite  = 1'b1;
                    end
                    if (opcode == OPC_JAL) begin
                        ctrlRegWrite = 1'b1;
                        ctrlRegDst   = REGDST_R2;
                        ctrlMemtoReg = MEMTOREG_PC;
                    end
                end
                S_EX: begin
                    case (opcode)
                        OPC_BNE, OPC_BEQ: begin
                            ctrlALUSrcA     = 1'b1;
                            ctrlALUOp       = ALU_SUB;
                            ctrlPCWriteCond = 1'b1;
                            ctrlPCSource    = PCSRC_ALUOUT;
                        end
                        OPC_BGZ, OPC_BLZ: begin
                            ctrlALUSrcA     = 1'b1;
                            ctrlALUSrcB     = SRCB_ZERO;
                            ctrlPCWriteCond = 1'b1;
                            ctrlPCSource    = PCSRC_ALUOUT;
                        end
                        OPC_ADI, OPC_LWD, OPC_SWD: begin
                            ctrlALUSrcA = 1'b1;
                            ctrlALUSrcB = SRCB_IMM;
                        end
                        OPC_ORI: begin
                            ctrlALUSrcA = 1'b1;
                            ctrlALUSrcB = SRCB_IMM;
                            ctrlALUOp   = ALU_OR;
                        end
                        OPC_RTYPE: begin
                            if (isAluFunc(func)) begin
                                ctrlALUSrcA = 1'b1;
                                ctrlALUOp   = func[2:0];
                            end else if (func == FUNC_JPR || func == FUNC_JRL) begin
                                ctrlALUSrcA = 1'b1;
                                ctrlALUSrcB = SRCB_ZERO;
                                ctrlPCWrite = 1'b1;
                                if (func == FUNC_JRL) begin
                                    ctrlRegWrite = 1'b1;
                                    ctrlRegDst   = REGDST_R2;
                                    ctrlMemtoReg = MEMTOREG_PC;
                                end
                            end else if (func == FUNC_WWD) begin
                                ctrlALUSrcA   = 1'b1;
                                ctrlALUSrcB   = SRCB_ZERO;
                                ctrlWritePort = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    readM2  = (opcode == OPC_LWD);
                    writeM2 = (opcode == OPC_SWD);
                end
                S_WB: begin
                    ctrlRegWrite = 1'b1;
                    if (opcode == OPC_LWD) begin
                        ctrlMemtoReg = MEMTOREG_MEM;
                    end else if (opcode == OPC_LHI) begin
                        ctrlMemtoReg = MEMTOREG_LHI;
                    end else if (opcode == OPC_RTYPE) begin
                        ctrlRegDst = REGDST_RD;
                    end
                end
                S_HALT: begin
                    isHalted = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: sequences the shared-ALU datapath of the 16-bit CPU
// through IF/ID/EX/MEM/WB, one instruction at a time, and parks on HLT.
// Ports:
//   clk, reset_n (async, active low)
//   inst     in  16  instruction word, captured when the fetch is acknowledged
//   mem_ack  in  1   memory completes the pending request this cycle
//   readM1/readM2/writeM2  out  memory requests, held until mem_ack
//   ctrl*    out  datapath strobes (see control_output_decode)
//   is_halted out 1  machine parked in HALT
//   num_inst out 16  retired-instruction count, wraps at 0xFFFF
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] inst,
    input  logic        mem_ack,
    output logic        readM1,
    output logic        readM2,
    output logic        writeM2,
    output logic        ctrlPCWrite,
    output logic        ctrlPCWriteCond,
    output logic        ctrlIRWrite,
    output logic        ctrlALUSrcA,
    output logic        ctrlRegWrite,
    output logic        ctrlWritePort,
    output logic [1:0]  ctrlMemtoReg,
    output logic [1:0]  ctrlPCSource,
    output logic [1:0]  ctrlALUSrcB,
    output logic [1:0]  ctrlRegDst,
    output logic [2:0]  ctrlALUOp,
    output logic        is_halted,
    output logic [15:0] num_inst
);

    stateT          state;
    stateT          nextState;
    logic [3:0]     opcodeQ;
    logic [5:0]     funcQ;
    logic [WORD_SIZE-1:0] numInst;
    logic           retire;

    // State register; reset always returns to IF, even mid memory request
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IF;
        end else begin
            state <= nextState;
        end
    end

    // Opcode/func are captured on the acknowledged fetch so that every later
    // state of this instruction decodes from a stable copy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opcodeQ <= 4'd0;
            funcQ   <= 6'd0;
        end else if (state == S_IF && mem_ack) begin
            opcodeQ <= inst[15:12];
            funcQ   <= inst[5:0];
        end
    end

    // Next-state selection; undefined codes fall through EX back to IF as NOPs
    always_comb begin
        nextState = state;
        case (state)
            S_IF: begin
                if (mem_ack) nextState = S_ID;
            end
            S_ID: begin
                if (opcodeQ == OPC_JMP || opcodeQ == OPC_JAL) begin
                    nextState = S_IF;
                end else if (opcodeQ == OPC_LHI) begin
                    nextState = S_WB;
                end else if (opcodeQ == OPC_RTYPE && funcQ == FUNC_HLT) begin
                    nextState = S_HALT;
                end else begin
                    nextState = S_EX;
                end
            end
            S_EX: begin
                if (opcodeQ == OPC_LWD || opcodeQ == OPC_SWD) begin
                    nextState = S_MEM;
                end else if (opcodeQ == OPC_ADI || opcodeQ == OPC_ORI ||
                             (opcodeQ == OPC_RTYPE && isAluFunc(funcQ))) begin
                    nextState = S_WB;
                end else begin
                    nextState = S_IF;
                end
            end
            S_MEM: begin
                if (mem_ack) nextState = (opcodeQ == OPC_LWD) ? S_WB : S_IF;
            end
            S_WB:    nextState = S_IF;
            S_HALT:  nextState = S_HALT;
            default: nextState = S_IF;
        endcase
    end

    // An instruction retires when the machine leaves its last working state
    assign retire = (state inside {S_ID, S_EX, S_MEM, S_WB}) &&
                    (nextState inside {S_IF, S_HALT});

    // Retired-instruction counter, free to wrap
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            numInst <= '0;
        end else if (retire) begin
            numInst <= numInst + 16'd1;
        end
    end

    assign num_inst = numInst;

    control_output_decode decode (
        .enable          (reset_n),
        .state           (state),
        .opcode          (opcodeQ),
        .func            (funcQ),
        .memAck          (mem_ack),
        .readM1          (readM1),
        .readM2          (readM2),
        .writeM2         (writeM2),
        .ctrlPCWrite     (ctrlPCWrite),
        .ctrlPCWriteCond (ctrlPCWriteCond),
        .ctrlIRWrite     (ctrlIRWrite),
        .ctrlALUSrcA     (ctrlALUSrcA),
        .ctrlRegWrite    (ctrlRegWrite),
        .ctrlWritePort   (ctrlWritePort),
        .ctrlMemtoReg    (ctrlMemtoReg),
        .ctrlPCSource    (ctrlPCSource),
        .ctrlALUSrcB     (ctrlALUSrcB),
        .ctrlRegDst      (ctrlRegDst),
        .ctrlALUOp       (ctrlALUOp),
        .isHalted        (is_halted)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: drives one cycle of stimulus per step,
// queues the hand-computed control word for that cycle, and a monitor
// compares the DUT outputs against the queue on the falling edge.
module tb_multicycle_control;

    typedef struct packed {
        logic        readM1;
        logic        readM2;
        logic        writeM2;
        logic        pcWrite;
        logic        pcWriteCond;
        logic        irWrite;
        logic        aluSrcA;
        logic        regWrite;
        logic        writePort;
        logic [1:0]  memtoReg;
        logic [1:0]  pcSource;
        logic [1:0]  aluSrcB;
        logic [1:0]  regDst;
        logic [2:0]  aluOp;
        logic        halted;
        logic [15:0] num;
    } ctrlT;

    typedef struct {
        string label;
        ctrlT  exp;
    } sbItemT;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] inst = 16'h0000;
    logic        mem_ack = 1'b0;
    logic        readM1, readM2, writeM2;
    logic        ctrlPCWrite, ctrlPCWriteCond, ctrlIRWrite, ctrlALUSrcA;
    logic        ctrlRegWrite, ctrlWritePort;
    logic [1:0]  ctrlMemtoReg, ctrlPCSource, ctrlALUSrcB, ctrlRegDst;
    logic [2:0]  ctrlALUOp;
    logic        is_halted;
    logic [15:0] num_inst;

    sbItemT      sbq[$];
    int          vectorCount = 0;
    int          errCount = 0;
    logic [15:0] expNum = 16'h0000;

    multicycle_control dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .inst            (inst),
        .mem_ack         (mem_ack),
        .readM1          (readM1),
        .readM2          (readM2),
        .writeM2         (writeM2),
        .ctrlPCWrite     (ctrlPCWrite),
        .ctrlPCWriteCond (ctrlPCWriteCond),
        .ctrlIRWrite     (ctrlIRWrite),
        .ctrlALUSrcA     (ctrlALUSrcA),
        .ctrlRegWrite    (ctrlRegWrite),
        .ctrlWritePort   (ctrlWritePort),
        .ctrlMemtoReg    (ctrlMemtoReg),
        .ctrlPCSource    (ctrlPCSource),
        .ctrlALUSrcB     (ctrlALUSrcB),
        .ctrlRegDst      (ctrlRegDst),
        .ctrlALUOp       (ctrlALUOp),
        .is_halted       (is_halted),
        .num_inst        (num_inst)
    );

    // 10-unit clock
    always #5 clk = ~clk;

    // All-zero control word carrying the currently expected count
    function automatic ctrlT base();
        ctrlT e;
        e = '0;
        e.num = expNum;
        return e;
    endfunction

    // IF cycle: request only, or request plus IR/PC update on the ack cycle
    function automatic ctrlT fetchVec(input logic ack);
        ctrlT e;
        e = base();
        e.readM1 = 1'b1;
        if (ack) begin
            e.irWrite = 1'b1;
            e.aluSrcB = 2'b01;
            e.pcWrite = 1'b1;
        end
        return e;
    endfunction

    // ID cycle common to every instruction: branch target into ALUOut
    function automatic ctrlT idVec();
        ctrlT e;
        e = base();
        e.aluSrcB = 2'b10;
        return e;
    endfunction

    function automatic void pushExp(input string label, input ctrlT e);
        sbItemT item;
        item.label = label;
        item.exp   = e;
        sbq.push_back(item);
    endfunction

    // One clock cycle of stimulus, applied just after the rising edge
    task automatic applyStimulus(input string label, input logic [15:0] instVal,
                                 input logic ack, input logic rstn, input ctrlT e);
        @(posedge clk);
        #1;
        inst    = instVal;
        mem_ack = ack;
        reset_n = rstn;
        pushExp(label, e);
    endtask

    task automatic checkOutput(input string label, input ctrlT exp);
        ctrlT act;
        act.readM1      = readM1;
        act.readM2      = readM2;
        act.writeM2     = writeM2;
        act.pcWrite     = ctrlPCWrite;
        act.pcWriteCond = ctrlPCWriteCond;
        act.irWrite     = ctrlIRWrite;
        act.aluSrcA     = ctrlALUSrcA;
        act.regWrite    = ctrlRegWrite;
        act.writePort   = ctrlWritePort;
        act.memtoReg    = ctrlMemtoReg;
        act.pcSource    = ctrlPCSource;
        act.aluSrcB     = ctrlALUSrcB;
        act.regDst      = ctrlRegDst;
        act.aluOp       = ctrlALUOp;
        act.halted      = is_halted;
        act.num         = num_inst;
        vectorCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %h expected %h", label, act, exp);
        end
    endtask

    // Monitor: one queued expectation is consumed per falling edge
    initial begin
        sbItemT item;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                item = sbq.pop_front();
                checkOutput(item.label, item.exp);
            end
        end
    end

    initial begin
        ctrlT e;

        // Reset held, then released, then dropped again mid-fetch
        applyStimulus("reset held 0", 16'h0000, 1'b0, 1'b0, base());
        applyStimulus("reset held 1", 16'h0000, 1'b0, 1'b0, base());
        applyStimulus("first fetch", 16'h0000, 1'b0, 1'b1, fetchVec(1'b0));
        applyStimulus("fetch wait", 16'h0000, 1'b0, 1'b1, fetchVec(1'b0));
        applyStimulus("reset mid-fetch", 16'h0000, 1'b0, 1'b0, base());
        applyStimulus("fetch after reset", 16'hF6C0, 1'b0, 1'b1, fetchVec(1'b0));

        // ADD R1=R2+R3; mem_ack high in EX/WB must be ignored
        applyStimulus("ADD IF", 16'hF6C0, 1'b1, 1'b1, fetchVec(1'b1));
        applyStimulus("ADD ID", 16'hF6C0, 1'b0, 1'b1, idVec());
        e = base(); e.aluSrcA = 1'b1;
        applyStimulus("ADD EX", 16'hF6C0, 1'b1, 1'b1, e);
        e = base(); e.regWrite = 1'b1; e.regDst = 2'b01;
        applyStimulus("ADD WB", 16'hF6C0, 1'b1, 1'b1, e);
        expNum = 16'd1;

        // LWD with three MEM wait cycles
        applyStimulus("LWD IF", 16'h7A05, 1'b1, 1'b1, fetchVec(1'b1));
        applyStimulus("LWD ID", 16'h7A05, 1'b0, 1'b1, idVec());
        e = base(); e.aluSrcA = 1'b1; e.aluSrcB = 2'b10;
        applyStimulus("LWD EX", 16'h7A05, 1'b0, 1'b1, e);
        e = base(); e.readM2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus("LWD MEM wait", 16'h7A05, 1'b0, 1'b1, e);
        end
        applyStimulus("LWD MEM ack", 16'h7A05, 1'b1, 1'b1, e);
        e = base(); e.regWrite = 1'b1; e.memtoReg = 2'b01;
        applyStimulus("LWD WB", 16'h7A05, 1'b0, 1'b1, e);
        expNum = 16'd2;

        // BEQ
        applyStimulus("BEQ IF", 16'h1003, 1'b1, 1'b1, fetchVec(1'b1));
        applyStimulus("BEQ ID", 16'h1003, 1'b0, 1'b1, idVec());
        e = base(); e.aluSrcA = 1'b1; e.aluOp = 3'd1; e.pcWriteCond = 1'b1; e.pcSource = 2'b01;
        applyStimulus("BEQ EX", 16'h1003, 1'b0, 1'b1, e);
        expNum = 16'd3;

        // JAL
        applyStimulus("JAL IF", 16'hA123, 1'b1, 1'b1, fetchVec(1'b1));
        e = idVec(); e.pcSource = 2'b10; e.pcWrite = 1'b1;
        e.regWrite = 1'b1; e.regDst = 2'b10; e.memtoReg = 2'b10;
        applyStimulus("JAL ID", 16'hA123, 1'b0, 1'b1, e);
        expNum = 16'd4;

        // SWD with one fetch wait cycle
        applyStimulus("SWD IF wait", 16'h8000, 1'b0, 1'b1, fetchVec(1'b0));
        applyStimulus("SWD IF", 16'h8000, 1'b1, 1'b1, fetchVec(1'b1));
        applyStimulus("SWD ID", 16'h8000, 1'b0, 1'b1, idVec());
        e = base(); e.aluSrcA = 1'b1; e.aluSrcB = 2'b10;
        applyStimulus("SWD EX", 16'h8000, 1'b0, 1'b1, e);
        e = base(); e.writeM2 = 1'b1;
        applyStimulus("SWD MEM", 16'h8000, 1'b1, 1'b1, e);
        expNum = 16'd5;

        // WWD
        applyStimulus("WWD IF", 16'hF01C, 1'b1, 1'b1, fetchVec(1'b1));
        applyStimulus("WWD ID", 16'hF01C, 1'b0, 1'b1, idVec());
        e = base(); e.aluSrcA = 1'b1; e.aluSrcB = 2'b11; e.writePort = 1'b1;
        applyStimulus("WWD EX", 16'hF01C, 1'b0, 1'b1, e);
        expNum = 16'd6;

        // ORI
        applyStimulus("ORI IF", 16'h5203, 1'b1, 1'b1, fetchVec(1'b1));
        applyStimulus("ORI ID", 16'h5203, 1'b0, 1'b1, idVec());
        e = base(); e.aluSrcA = 1'b1; e.aluSrcB = 2'b10; e.aluOp = 3'd3;
        applyStimulus("ORI EX", 16'h5203, 1'b0, 1'b1, e);
        e = base(); e.regWrite = 1'b1;
        applyStimulus("ORI WB", 16'h5203, 1'b0, 1'b1, e);
        expNum = 16'd7;

        // LHI skips EX
        applyStimulus("LHI IF", 16'h6123, 1'b1, 1'b1, fetchVec(1'b1));
        applyStimulus("LHI ID", 16'h6123, 1'b0, 1'b1, idVec());
        e = base(); e.regWrite = 1'b1; e.memtoReg = 2'b11;
        applyStimulus("LHI WB", 16'h6123, 1'b0, 1'b1, e);
        expNum = 16'd8;

        // Undefined opcode behaves as NOP but still retires
        applyStimulus("NOP IF", 16'hB000, 1'b1, 1'b1, fetchVec(1'b1));
        applyStimulus("NOP ID", 16'hB000, 1'b0, 1'b1, idVec());
        applyStimulus("NOP EX", 16'hB000, 1'b0, 1'b1, base());
        expNum = 16'd9;

        // JPR
        applyStimulus("JPR IF", 16'hF019, 1'b1, 1'b1, fetchVec(1'b1));
        applyStimulus("JPR ID", 16'hF019, 1'b0, 1'b1, idVec());
        e = base(); e.aluSrcA = 1'b1; e.aluSrcB = 2'b11; e.pcWrite = 1'b1;
        applyStimulus("JPR EX", 16'hF019, 1'b0, 1'b1, e);
        expNum = 16'd10;

        // R-type NOT (func 4)
        applyStimulus("NOT IF", 16'hF004, 1'b1, 1'b1, fetchVec(1'b1));
        applyStimulus("NOT ID", 16'hF004, 1'b0, 1'b1, idVec());
        e = base(); e.aluSrcA = 1'b1; e.aluOp = 3'd4;
        applyStimulus("NOT EX", 16'hF004, 1'b0, 1'b1, e);
        e = base(); e.regWrite = 1'b1; e.regDst = 2'b01;
        applyStimulus("NOT WB", 16'hF004, 1'b0, 1'b1, e);
        expNum = 16'd11;

        // Preload the counter to 0xFFFF so HLT's retirement exercises the wrap
        @(posedge clk);
        #1;
        force dut.numInst = 16'hFFFF;
        release dut.numInst;
        expNum  = 16'hFFFF;
        inst    = 16'hF01D;
        mem_ack = 1'b1;
        pushExp("HLT IF", fetchVec(1'b1));
        applyStimulus("HLT ID", 16'hF01D, 1'b0, 1'b1, idVec());
        expNum = 16'h0000;
        e = base(); e.halted = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus("HALT hold", 16'hF01D, 1'(i % 2), 1'b1, e);
        end

        // Only reset leaves HALT
        applyStimulus("reset from HALT", 16'h0000, 1'b0, 1'b0, base());
        applyStimulus("fetch after HALT", 16'h0000, 1'b0, 1'b1, fetchVec(1'b0));

        // Every queued expectation must have been consumed
        @(negedge clk);
        #1;
        vectorCount++;
        if (sbq.size() != 0) begin
            errCount++;
            $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", sbq.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, errCount);
        $finish;
    end

endmodule
